// File: rtl/sat_mac_accumulator.sv
// Single-neuron fixed-point MAC: loads a bias, accumulates LEN truncated Q-format products
// with guard bits, then presents one saturated N-bit result over a valid/ready handshake.
module sat_mac_accumulator #(
  parameter int unsigned N   = 10,
  parameter int unsigned Q   = 9,
  parameter int unsigned LEN = 4,
  parameter int unsigned G   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] bias,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         sat
);

  localparam int unsigned AW = N + 1 + G;
  localparam int unsigned CW = (LEN > 1) ? $clog2(LEN) : 1;

  localparam logic [CW-1:0]        LastCnt = CW'(LEN - 1);
  localparam logic signed [AW-1:0] MaxVal  = AW'((1 << (N - 1)) - 1);
  localparam logic signed [AW-1:0] MinVal  = ~MaxVal;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [N-1:0]         out_q, out_d;
  logic                 sat_q, sat_d;

  logic signed [2*N-1:0] prod;
  logic signed [N:0]     term_w;
  logic signed [AW-1:0]  term;
  logic signed [AW-1:0]  bias_ext;
  logic signed [AW-1:0]  sum;
  logic [N-1:0]          sum_sat;
  logic                  sum_clip;

  // Arithmetic shift floors toward -inf; the shifted product always fits in N+1 bits.
  assign prod     = $signed(a) * $signed(b);
  assign term_w   = (N + 1)'(prod >>> Q);
  assign term     = {{G{term_w[N]}}, term_w};
  assign bias_ext = {{(G + 1){bias[N-1]}}, bias};
  assign sum      = acc_q + term;

  // Saturate the sum that includes the final beat, so the result is ready on DONE entry.
  always_comb begin
    sum_sat  = sum[N-1:0];
    sum_clip = 1'b0;
    if (sum > MaxVal) begin
      sum_sat  = MaxVal[N-1:0];
      sum_clip = 1'b1;
    end else if (sum < MinVal) begin
      sum_sat  = MinVal[N-1:0];
      sum_clip = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    sat_d   = sat_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = bias_ext;
          cnt_d   = '0;
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (in_valid) begin
          acc_d = sum;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            out_d   = sum_sat;
            sat_d   = sum_clip;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q == StAcc);
  assign out_valid = (state_q == StDone);
  assign out       = out_q;
  assign sat       = sat_q;

  // A stalled result must not change under the consumer.
  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out) && $stable(sat)));

  a_one_side: assert property (@(posedge clk) !(in_ready && out_valid));

endmodule
